aftab_multiplier: RTL and testbench

- Sequential radix-2 shift-add unsigned multiplier for the AFTAB AAU; the inverse-operation companion of the AAU divider.
- Takes two len-bit operands and produces a 2*len-bit product.
- Uses the same start/ready handshake as the divider, so the AAU controller drives both units identically.
- Sign handling (33-bit sign-extended operands for MUL/MULH/MULHSU/MULHU) stays outside this block, in the signed/unsigned wrapper.

---
 rtl/aftab_aau_pkg.sv | 12 +
 rtl/aftab_mul_datapath.sv | 49 ++++
 rtl/aftab_multiplier.sv | 84 ++++++++
 tb/tb_aftab_multiplier.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/aftab_aau_pkg.sv
// Shared AAU definitions: default operand width and multiplier state encoding.
package aftab_aau_pkg;

    localparam int AAU_LEN = 33;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/aftab_mul_datapath.sv
// Radix-2 shift-add datapath: operand/partial-product registers, adder and result register.
module aftab_mul_datapath #(
    parameter int LEN = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_capture,
    input  logic [LEN-1:0]   i_mcand,
    input  logic [LEN-1:0]   i_mplier,
    output logic [2*LEN-1:0] o_product
);

    logic [LEN-1:0]   r_mcand;
    logic [LEN-1:0]   r_acc;
    logic [LEN-1:0]   r_mq;
    logic [2*LEN-1:0] r_product;
    logic [LEN:0]     w_addend;
    logic [LEN:0]     w_sum;

    assign w_addend = r_mq[0] ? {1'b0, r_mcand} : '0;
    assign w_sum    = {1'b0, r_acc} + w_addend;

    // The carry bit lives only in w_sum; the shift moves it straight into acc's MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_mcand <= i_mcand;
                r_mq    <= i_mplier;
                r_acc   <= '0;
            end else if (i_step) begin
                r_acc <= w_sum[LEN:1];
                r_mq  <= {w_sum[0], r_mq[LEN-1:1]};
            end
            if (i_capture) begin
                r_product <= {r_acc, r_mq};
            end
        end
    end

    assign o_product = r_product;

endmodule

// File: rtl/aftab_multiplier.sv
// Sequential unsigned shift-add multiplier with the AAU start/ready handshake.
// Fixed latency of len+2 cycles from accepted start to the ready pulse.
import aftab_aau_pkg::*;

module aftab_multiplier #(
    parameter int len = AAU_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [len-1:0]   Multiplicand,
    input  logic [len-1:0]   Multiplier,
    output logic [2*len-1:0] Product,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(len) + 1;
    localparam logic [CW-1:0] LAST = CW'(len - 1);

    mul_state_e    r_state;
    logic [CW-1:0] r_count;
    logic          r_ready;
    logic          r_busy;
    logic          w_load;
    logic          w_step;
    logic          w_capture;

    assign w_load    = (r_state == MUL_IDLE) && start;
    assign w_step    = (r_state == MUL_RUN);
    assign w_capture = (r_state == MUL_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MUL_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_state <= MUL_RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= MUL_IDLE;
                end
                default: begin
                    r_state <= MUL_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    aftab_mul_datapath #(
        .LEN(len)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_capture (w_capture),
        .i_mcand   (Multiplicand),
        .i_mplier  (Multiplier),
        .o_product (Product)
    );

    assign ready = r_ready;
    assign busy  = r_busy;

endmodule

// File: tb/tb_aftab_multiplier.sv
// Self-checking bench for aftab_multiplier: vector table, scoreboard and handshake corner cases.
module tb_aftab_multiplier;

    localparam int LEN = 33;

    typedef struct {
        logic [LEN-1:0]   a;
        logic [LEN-1:0]   b;
        logic [2*LEN-1:0] p;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN-1:0]   A;
    logic [LEN-1:0]   B;
    logic [2*LEN-1:0] Product;
    logic             ready;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int ready_cnt = 0;

    logic [2*LEN-1:0] q[$];
    int m_left  = 0;
    bit m_ready = 1'b0;

    vec_t vecs[8];

    aftab_multiplier #(.len(LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Multiplicand (A),
        .Multiplier   (B),
        .Product      (Product),
        .ready        (ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2*LEN-1:0] act, input logic [2*LEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: acceptance only when idle, result due len+2 cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left  = 0;
            m_ready = 1'b0;
            q.delete();
        end else begin
            m_ready = (m_left == 1);
            if (m_left != 0) begin
                m_left--;
            end else if (start) begin
                q.push_back({{LEN{1'b0}}, A} * {{LEN{1'b0}}, B});
                m_left = LEN + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready_vs_model", {65'b0, ready}, {65'b0, m_ready});
        chk("busy_vs_model", {65'b0, busy}, {65'b0, (m_left != 0)});
        if (ready) begin
            ready_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_ready: got product %0h with no pending operation", Product);
            end else begin
                chk("sb_product", Product, q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          input logic [2*LEN-1:0] exp, input string nm);
        int n;
        bit seen;
        @(posedge clk); #1;
        A = a; B = b; start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < LEN + 10) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
            if (ready) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready within %0d cycles, required ready", nm, n);
        end else begin
            chk({nm, "_latency"}, 66'(n), 66'(LEN + 2));
            chk({nm, "_product"}, Product, exp);
            @(posedge clk); #1;
            chk({nm, "_hold"}, Product, exp);
        end
    endtask

    initial begin
        int n;
        int rc0;
        logic [2*LEN-1:0] prev;

        vecs[0] = '{a: 33'd120, b: 33'd7, p: 66'd840};
        vecs[1] = '{a: 33'h1_FFFF_FFFF, b: 33'h1_FFFF_FFFF, p: 66'h3_FFFF_FFFC_0000_0001};
        vecs[2] = '{a: 33'd12345, b: 33'd0, p: 66'd0};
        vecs[3] = '{a: 33'd0, b: 33'd1, p: 66'd0};
        vecs[4] = '{a: 33'd1, b: 33'h1_FFFF_FFFF, p: 66'h1_FFFF_FFFF};
        vecs[5] = '{a: 33'h1_0000_0000, b: 33'd2, p: 66'h2_0000_0000};
        vecs[6] = '{a: 33'h0ABCD, b: 33'h01234, p: 66'd204951460};
        vecs[7] = '{a: 33'd1, b: 33'd1, p: 66'd1};

        rst = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_product", Product, 66'd0);
        chk("reset_ready", {65'b0, ready}, 66'd0);
        chk("reset_busy", {65'b0, busy}, 66'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Start held high with operands changing every cycle.
        @(posedge clk); #1;
        rc0 = ready_cnt;
        A = 33'({$urandom(), $urandom()});
        B = 33'({$urandom(), $urandom()});
        start = 1'b1;
        for (int i = 0; i < 3 * (LEN + 2); i++) begin
            @(posedge clk); #1;
            A = 33'({$urandom(), $urandom()});
            B = 33'({$urandom(), $urandom()});
        end
        start = 1'b0;
        repeat (LEN + 6) @(posedge clk);
        #1;
        chk("held_start_ready_count", 66'(ready_cnt - rc0), 66'd3);

        // Reset during RUN aborts the operation.
        run_op(33'd11, 33'd13, 66'd143, "pre_abort");
        @(posedge clk); #1;
        A = 33'd5; B = 33'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_product", Product, 66'd0);
        chk("abort_ready", {65'b0, ready}, 66'd0);
        chk("abort_busy", {65'b0, busy}, 66'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rc0 = ready_cnt;
        repeat (LEN + 4) @(posedge clk);
        #1;
        chk("abort_no_ready", 66'(ready_cnt - rc0), 66'd0);
        run_op(33'd6, 33'd7, 66'd42, "after_abort");

        // start and operand changes while busy and in DONE are ignored.
        @(posedge clk); #1;
        rc0 = ready_cnt;
        A = 33'd3; B = 33'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        prev = Product;
        while (!ready && n < LEN + 10) begin
            if (n == 5 || n == 20 || n == LEN) begin
                A = 33'({$urandom(), $urandom()});
                B = 33'({$urandom(), $urandom()});
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("rerun_latency", 66'(n), 66'(LEN + 2));
        chk("rerun_product", Product, 66'd12);
        chk("rerun_prev_differs", {65'b0, (prev != Product)}, 66'd1);
        repeat (LEN + 4) @(posedge clk);
        #1;
        chk("rerun_ready_count", 66'(ready_cnt - rc0), 66'd1);
        chk("rerun_product_hold", Product, 66'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
